tdm_demux4: RTL and testbench

- 4-channel time-division demultiplexer: the receive-side counterpart of our 4:1 select-line mux.
- Takes a bit-serial interleaved stream, where slot s0/s1 selects the channel exactly as the mux select does.
- Steers each bit into one of four per-channel shift registers.
- Presents four parallel WIDTH-bit words with a one-cycle frame_valid strobe.
- Sits between the serial link and the per-channel boolean/mux datapaths.

---
 rtl/tdm_pkg.sv | 19 +
 rtl/tdm_slot_cnt.sv | 40 ++++
 rtl/tdm_demux4.sv | 149 ++++++++++++++
 tb/tb_tdm_demux4.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/tdm_pkg.sv
// Shared definitions for the 4-channel TDM demultiplexer.
// Optional build macro: TDM_PARITY_EN (adds a trailing even-parity bit per frame).
package tdm_pkg;

  localparam int NUM_CH = 4;
  localparam int SLOT_W = 2;

  typedef enum logic [1:0] {
    HUNT = 2'b00,
    RECV = 2'b01,
    PAR  = 2'b10
  } tdm_state_e;

  // True when the accumulated data parity combined with the received parity bit is even.
  function automatic logic even_par_ok(input logic acc, input logic par_bit);
    return ((acc ^ par_bit) == 1'b0);
  endfunction

endpackage

// File: rtl/tdm_slot_cnt.sv
// Slot (channel) and bit-row counter for the TDM demultiplexer.
// restart_i loads the post-sync position (slot 1, row 0); adv_i steps one enabled bit.
module tdm_slot_cnt
  import tdm_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              adv_i,
  input  logic              restart_i,
  output logic [SLOT_W-1:0] slot_o,
  output logic              wrap_o,
  output logic              last_o
);

  logic [SLOT_W-1:0] slot_q;
  logic [3:0]        k_q;

  assign slot_o = slot_q;
  assign wrap_o = (slot_q == 2'd3);
  assign last_o = (k_q == 4'(WIDTH - 1));

  // Slot increments every enabled bit; the row counter advances on slot wrap and clears after the last row.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q <= 2'd0;
      k_q    <= 4'd0;
    end else if (restart_i) begin
      slot_q <= 2'd1;
      k_q    <= 4'd0;
    end else if (adv_i) begin
      slot_q <= slot_q + 2'd1;
      if (wrap_o) begin
        k_q <= last_o ? 4'd0 : (k_q + 4'd1);
      end
    end
  end

endmodule

// File: rtl/tdm_demux4.sv
// 4-channel bit-serial TDM demultiplexer: interleaved MSB-first stream into four WIDTH-bit words.
// Optional build macro: TDM_PARITY_EN (frame carries one extra even-parity bit, checked before loading).
module tdm_demux4
  import tdm_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             sync,
  input  logic             din,
  output logic [WIDTH-1:0] ch0,
  output logic [WIDTH-1:0] ch1,
  output logic [WIDTH-1:0] ch2,
  output logic [WIDTH-1:0] ch3,
  output logic             frame_valid,
  output logic             busy,
  output logic             sync_err,
  output logic             par_err
);

  tdm_state_e        state_q;
  logic [WIDTH-1:0]  sr_q  [NUM_CH];
  logic [WIDTH-1:0]  ch_q  [NUM_CH];
  logic [WIDTH-1:0]  sr_nx_s [NUM_CH];
  logic              fv_q;
  logic              busy_q;
  logic              se_q;
  logic [SLOT_W-1:0] slot_s;
  logic              wrap_s;
  logic              last_s;
  logic              start_s;
  logic              adv_s;

  assign start_s = en & sync;
  assign adv_s   = en & ~sync & (state_q == RECV);

  tdm_slot_cnt #(.WIDTH(WIDTH)) u_cnt (
    .clk       (clk),
    .rst_n     (rst_n),
    .adv_i     (adv_s),
    .restart_i (start_s),
    .slot_o    (slot_s),
    .wrap_o    (wrap_s),
    .last_o    (last_s)
  );

  // Each shift register's value with the current din appended at the LSB end.
  always_comb begin
    for (int j = 0; j < NUM_CH; j++) begin
      sr_nx_s[j] = (sr_q[j] << 1'b1) | WIDTH'(din);
    end
  end

`ifdef TDM_PARITY_EN
  logic par_q;
  logic pe_q;
  assign par_err = pe_q;
`else
  assign par_err = 1'b0;
`endif

  // Frame FSM: steers bits into shift registers, loads the output words and raises the status pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= HUNT;
      fv_q    <= 1'b0;
      busy_q  <= 1'b0;
      se_q    <= 1'b0;
      for (int j = 0; j < NUM_CH; j++) begin
        sr_q[j] <= '0;
        ch_q[j] <= '0;
      end
`ifdef TDM_PARITY_EN
      par_q <= 1'b0;
      pe_q  <= 1'b0;
`endif
    end else begin
      fv_q <= 1'b0;
      se_q <= 1'b0;
`ifdef TDM_PARITY_EN
      pe_q <= 1'b0;
`endif
      if (start_s) begin
        // Sync always (re)starts a frame with din as the ch0 MSB; mid-frame it aborts the old one.
        sr_q[0] <= sr_nx_s[0];
        se_q    <= (state_q != HUNT);
        state_q <= RECV;
        busy_q  <= 1'b1;
`ifdef TDM_PARITY_EN
        par_q <= din;
`endif
      end else if (en) begin
        case (state_q)
          HUNT: begin
            state_q <= HUNT;
          end
          RECV: begin
            sr_q[slot_s] <= sr_nx_s[slot_s];
`ifdef TDM_PARITY_EN
            par_q <= par_q ^ din;
            if (wrap_s && last_s) begin
              state_q <= PAR;
            end
`else
            if (wrap_s && last_s) begin
              ch_q[0] <= sr_q[0];
              ch_q[1] <= sr_q[1];
              ch_q[2] <= sr_q[2];
              ch_q[3] <= sr_nx_s[3];
              fv_q    <= 1'b1;
              state_q <= HUNT;
              busy_q  <= 1'b0;
            end
`endif
          end
`ifdef TDM_PARITY_EN
          PAR: begin
            if (even_par_ok(par_q, din)) begin
              for (int j = 0; j < NUM_CH; j++) begin
                ch_q[j] <= sr_q[j];
              end
              fv_q <= 1'b1;
            end else begin
              pe_q <= 1'b1;
            end
            state_q <= HUNT;
            busy_q  <= 1'b0;
          end
`endif
          default: begin
            state_q <= HUNT;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign ch0         = ch_q[0];
  assign ch1         = ch_q[1];
  assign ch2         = ch_q[2];
  assign ch3         = ch_q[3];
  assign frame_valid = fv_q;
  assign busy        = busy_q;
  assign sync_err    = se_q;

endmodule

// File: tb/tb_tdm_demux4.sv
// Directed self-checking bench for tdm_demux4 (WIDTH=4, default build without TDM_PARITY_EN).
module tb_tdm_demux4;

  localparam int WIDTH = 4;

  logic clk = 1'b0;
  logic rst_n, en, sync, din;
  logic [WIDTH-1:0] ch0, ch1, ch2, ch3;
  logic frame_valid, busy, sync_err, par_err;

  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;
  int t0;
  int tlen;
  logic [15:0] w;

  always #5 clk = ~clk;

  tdm_demux4 #(.WIDTH(WIDTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .sync        (sync),
    .din         (din),
    .ch0         (ch0),
    .ch1         (ch1),
    .ch2         (ch2),
    .ch3         (ch3),
    .frame_valid (frame_valid),
    .busy        (busy),
    .sync_err    (sync_err),
    .par_err     (par_err)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of inputs, then sample 1 time unit after the rising edge.
  task automatic step(input logic e, input logic s, input logic d);
    en = e; sync = s; din = d;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Send a 16-bit frame MSB-first with sync on bit 0, optionally pausing en after bit gap_at.
  task automatic send16(input logic [15:0] word, input int gap_at, input int gap_len);
    for (int i = 0; i < 16; i++) begin
      step(1'b1, (i == 0), word[15-i]);
      if (i < 15) begin
        chk("frm_fv_low", {15'd0, frame_valid}, 16'd0);
        chk("frm_busy", {15'd0, busy}, 16'd1);
      end
      if (i == gap_at) begin
        for (int g = 0; g < gap_len; g++) begin
          step(1'b0, 1'b1, g[0]);
          chk("gap_busy", {15'd0, busy}, 16'd1);
          chk("gap_strobes", {14'd0, frame_valid, sync_err}, 16'd0);
        end
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; sync = 1'b0; din = 1'b0;
    #12;
    chk("rst_ch", {ch0, ch1, ch2, ch3}, 16'h0000);
    chk("rst_flags", {12'd0, frame_valid, busy, sync_err, par_err}, 16'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic frame A,5,3,C
    t0 = cyc;
    send16(16'h95A6, -1, 0);
    tlen = cyc - t0;
    chk("f1_fv", {15'd0, frame_valid}, 16'd1);
    chk("f1_ch", {ch0, ch1, ch2, ch3}, 16'hA53C);
    chk("f1_busy", {15'd0, busy}, 16'd0);
    chk("f1_serr", {14'd0, sync_err, par_err}, 16'd0);
    chk("f1_lat", tlen[15:0], 16'd16);

    // Back-to-back: next frame aborted by sync at bit 9, then the 0000 frame completes
    w = 16'h95A6;
    for (int i = 0; i < 9; i++) begin
      step(1'b1, (i == 0), w[15-i]);
      if (i == 0) begin
        chk("b2b_fv_pulse_end", {15'd0, frame_valid}, 16'd0);
        chk("b2b_busy", {15'd0, busy}, 16'd1);
      end
      chk("ab_serr_low", {15'd0, sync_err}, 16'd0);
    end
    step(1'b1, 1'b1, 1'b0);
    chk("ab_serr", {15'd0, sync_err}, 16'd1);
    chk("ab_fv", {15'd0, frame_valid}, 16'd0);
    chk("ab_ch_hold", {ch0, ch1, ch2, ch3}, 16'hA53C);
    chk("ab_busy", {15'd0, busy}, 16'd1);
    for (int i = 1; i < 16; i++) begin
      step(1'b1, 1'b0, 1'b0);
      if (i == 1) chk("ab_serr_pulse_end", {15'd0, sync_err}, 16'd0);
      if (i < 15) chk("ab_fv_low", {15'd0, frame_valid}, 16'd0);
    end
    chk("z_fv", {15'd0, frame_valid}, 16'd1);
    chk("z_ch", {ch0, ch1, ch2, ch3}, 16'h0000);
    chk("z_serr", {15'd0, sync_err}, 16'd0);
    step(1'b0, 1'b0, 1'b0);
    chk("z_idle_fv", {15'd0, frame_valid}, 16'd0);
    chk("z_idle_ch", {ch0, ch1, ch2, ch3}, 16'h0000);

    // Same A,5,3,C frame with en low for 3 cycles after bit 7
    t0 = cyc;
    send16(16'h95A6, 7, 3);
    tlen = cyc - t0;
    chk("g_fv", {15'd0, frame_valid}, 16'd1);
    chk("g_ch", {ch0, ch1, ch2, ch3}, 16'hA53C);
    chk("g_lat", tlen[15:0], 16'd19);
    step(1'b0, 1'b0, 1'b0);
    chk("g_idle_fv", {15'd0, frame_valid}, 16'd0);

    // Asynchronous reset mid-frame after 6 bits
    for (int i = 0; i < 6; i++) begin
      step(1'b1, (i == 0), w[15-i]);
    end
    #3;
    rst_n = 1'b0;
    #1;
    chk("ar_ch", {ch0, ch1, ch2, ch3}, 16'h0000);
    chk("ar_busy", {15'd0, busy}, 16'd0);
    @(posedge clk);
    #1;
    chk("ar_hold_busy", {15'd0, busy}, 16'd0);
    #3;
    rst_n = 1'b1;

    // Stray din in HUNT without sync: no activity
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 1'b0, i[0]);
      chk("hunt_busy", {15'd0, busy}, 16'd0);
      chk("hunt_strobes", {13'd0, frame_valid, sync_err, par_err}, 16'd0);
    end
    chk("hunt_ch", {ch0, ch1, ch2, ch3}, 16'h0000);

    // Frame after recovery: ch0=1, ch1=2, ch2=4, ch3=8
    send16(16'h1248, -1, 0);
    chk("f4_fv", {15'd0, frame_valid}, 16'd1);
    chk("f4_ch", {ch0, ch1, ch2, ch3}, 16'h1248);
    chk("f4_perr", {15'd0, par_err}, 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
